// File: rtl/edid_update_ctrl.sv
// edid_update_ctrl: safe EDID content update sequencer.
// Drops HPD, waits for the DDC bus to go idle, locks I2C access to the EDID
// RAM, opens a host write window, then walks each 128-byte block to verify or
// patch its checksum before reasserting HPD after a minimum low time.
// Optional feature macro: EDID_CKSUM_FIX_EN. When defined, byte 127 of every
// block is recomputed and written back. When undefined, the blocks are only
// verified (byte 127 included in the sum) and the RAM is never written.
module edid_update_ctrl #(
    parameter int NumBlocks    = 2,
    parameter int HpdLowCycles = 5000000,
    parameter int CntWidth     = 23
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        update_req_i,
    input  logic        commit_i,
    input  logic        i2c_active_i,
    output logic        hpd_o,
    output logic        edid_lock_o,
    output logic        host_wr_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        cksum_ok_o,
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [5:0]  ram_addr_o,
    output logic [31:0] ram_wdata_o,
    output logic [3:0]  ram_wmask_o,
    input  logic        ram_gnt_i,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_LOCK    = 3'd2,
        ST_SUM     = 3'd3,
        ST_FIX     = 3'd4,
        ST_HPDWAIT = 3'd5
    } state_e;

    localparam logic [CntWidth-1:0] HpdLowMax = CntWidth'(HpdLowCycles);
    localparam logic [CntWidth-1:0] TimerOne  = CntWidth'(1);
    localparam logic                LastBlk   = 1'(NumBlocks - 1);

    // Modulo-256 sum of the bytes of one RAM word; drop_top leaves out byte 3,
    // which is the checksum byte position in the last word of a block.
    function automatic logic [7:0] word_sum(input logic [31:0] w, input logic drop_top);
        logic [7:0] s;
        s = w[7:0] + w[15:8] + w[23:16];
        s = s + (drop_top ? 8'h00 : w[31:24]);
        return s;
    endfunction

    state_e              state_r;
    logic [CntWidth-1:0] timer_r;
    logic                blk_r;
    logic [4:0]          idx_r;
    logic [7:0]          acc_r;
    logic                pend_r;
`ifndef EDID_CKSUM_FIX_EN
    logic                all_ok_r;
`endif
    logic                hpd_r;
    logic                lock_r;
    logic                wr_en_r;
    logic                busy_r;
    logic                done_r;
    logic                cksum_ok_r;
    logic                ram_req_r;
    logic                ram_we_r;
    logic [5:0]          ram_addr_r;
    logic [31:0]         ram_wdata_r;
    logic [3:0]          ram_wmask_r;

    logic                last_word_s;
    logic [7:0]          sum_s;

    // Block sum including the word currently returning from the RAM
    always_comb begin
        last_word_s = (idx_r == 5'd31);
`ifdef EDID_CKSUM_FIX_EN
        sum_s = acc_r + word_sum(ram_rdata_i, last_word_s);
`else
        sum_s = acc_r + word_sum(ram_rdata_i, 1'b0);
`endif
    end

    // Update sequencer: state, HPD low timer, RAM port and all registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            blk_r       <= 1'b0;
            idx_r       <= 5'd0;
            acc_r       <= 8'h00;
            pend_r      <= 1'b0;
`ifndef EDID_CKSUM_FIX_EN
            all_ok_r    <= 1'b0;
`endif
            hpd_r       <= 1'b0;
            lock_r      <= 1'b0;
            wr_en_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cksum_ok_r  <= 1'b0;
            ram_req_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= 6'd0;
            ram_wdata_r <= 32'h0000_0000;
            ram_wmask_r <= 4'b0000;
        end else begin
            done_r <= 1'b0;
            // HPD low time counter, saturating at the required minimum
            if (!hpd_r && (timer_r != HpdLowMax)) begin
                timer_r <= timer_r + TimerOne;
            end
            case (state_r)
                ST_IDLE: begin
                    if (update_req_i) begin
                        state_r    <= ST_DRAIN;
                        hpd_r      <= 1'b0;
                        timer_r    <= '0;
                        busy_r     <= 1'b1;
                        cksum_ok_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!i2c_active_i) begin
                        state_r <= ST_LOCK;
                        lock_r  <= 1'b1;
                        wr_en_r <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (commit_i) begin
                        state_r    <= ST_SUM;
                        wr_en_r    <= 1'b0;
                        blk_r      <= 1'b0;
                        idx_r      <= 5'd0;
                        acc_r      <= 8'h00;
                        pend_r     <= 1'b0;
`ifndef EDID_CKSUM_FIX_EN
                        all_ok_r   <= 1'b1;
`endif
                        ram_req_r  <= 1'b1;
                        ram_we_r   <= 1'b0;
                        ram_addr_r <= 6'd0;
                    end
                end
                ST_SUM: begin
                    if (ram_req_r && ram_gnt_i) begin
                        ram_req_r <= 1'b0;
                        pend_r    <= 1'b1;
                    end else if (pend_r && ram_rvalid_i) begin
                        pend_r <= 1'b0;
                        if (!last_word_s) begin
                            acc_r      <= sum_s;
                            idx_r      <= idx_r + 5'd1;
                            ram_req_r  <= 1'b1;
                            ram_addr_r <= {blk_r, idx_r + 5'd1};
                        end else begin
`ifdef EDID_CKSUM_FIX_EN
                            state_r     <= ST_FIX;
                            ram_req_r   <= 1'b1;
                            ram_we_r    <= 1'b1;
                            ram_addr_r  <= {blk_r, 5'd31};
                            ram_wdata_r <= {8'h00 - sum_s, 24'h00_0000};
                            ram_wmask_r <= 4'b1000;
`else
                            all_ok_r <= all_ok_r & (sum_s == 8'h00);
                            if (blk_r != LastBlk) begin
                                blk_r      <= blk_r + 1'b1;
                                idx_r      <= 5'd0;
                                acc_r      <= 8'h00;
                                ram_req_r  <= 1'b1;
                                ram_addr_r <= {blk_r + 1'b1, 5'd0};
                            end else begin
                                cksum_ok_r <= all_ok_r & (sum_s == 8'h00);
                                state_r    <= ST_HPDWAIT;
                            end
`endif
                        end
                    end
                end
                ST_FIX: begin
                    if (ram_gnt_i) begin
                        ram_we_r    <= 1'b0;
                        ram_wdata_r <= 32'h0000_0000;
                        ram_wmask_r <= 4'b0000;
                        if (blk_r != LastBlk) begin
                            state_r    <= ST_SUM;
                            blk_r      <= blk_r + 1'b1;
                            idx_r      <= 5'd0;
                            acc_r      <= 8'h00;
                            ram_req_r  <= 1'b1;
                            ram_addr_r <= {blk_r + 1'b1, 5'd0};
                        end else begin
                            ram_req_r  <= 1'b0;
                            cksum_ok_r <= 1'b1;
                            state_r    <= ST_HPDWAIT;
                        end
                    end
                end
                ST_HPDWAIT: begin
                    if (timer_r == HpdLowMax) begin
                        hpd_r   <= 1'b1;
                        lock_r  <= 1'b0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign hpd_o        = hpd_r;
    assign edid_lock_o  = lock_r;
    assign host_wr_en_o = wr_en_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign cksum_ok_o   = cksum_ok_r;
    assign ram_req_o    = ram_req_r;
    assign ram_we_o     = ram_we_r;
    assign ram_addr_o   = ram_addr_r;
    assign ram_wdata_o  = ram_wdata_r;
    assign ram_wmask_o  = ram_wmask_r;

endmodule

// File: tb/tb_edid_update_ctrl.sv
// Testbench for edid_update_ctrl: byte-level checksum reference model, a
// RAM responder with programmable grant delay / read latency, and directed
// update sequences with randomized EDID contents and timing.
// Follows EDID_CKSUM_FIX_EN the same way the design does.
`timescale 1ns/1ps
module tb_edid_update_ctrl;
    localparam int NB      = 2;
    localparam int HPD_LOW = 16;
    localparam int CW      = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        update_req;
    logic        commit;
    logic        i2c_active;
    logic        hpd;
    logic        lock;
    logic        host_wr_en;
    logic        busy;
    logic        done;
    logic        cksum_ok;
    logic        ram_req;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wmask;
    logic        ram_gnt;
    logic        ram_rvalid;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    edid_update_ctrl #(.NumBlocks(NB), .HpdLowCycles(HPD_LOW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .update_req_i(update_req), .commit_i(commit),
        .i2c_active_i(i2c_active), .hpd_o(hpd), .edid_lock_o(lock),
        .host_wr_en_o(host_wr_en), .busy_o(busy), .done_o(done), .cksum_ok_o(cksum_ok),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_gnt_i(ram_gnt),
        .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [64];
    int          gnt_delay = 0;
    int          rv_lat = 1;
    int          n_rd = 0;
    int          n_wr = 0;
    logic [3:0]  last_wmask = 4'b0000;
    int          wait_cnt = 0;
    int          rv_cnt = 0;
    logic [31:0] rd_hold = 32'h0;
    bit          held = 1'b0;
    bit          outst = 1'b0;
    logic [43:0] held_sig = 44'h0;
    int          low_cnt = 0;
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: modulo-256 sum over the bytes of block b
    function automatic logic [7:0] blk_sum(input int b, input bit skip_last);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 128; i++) begin
            if (!(skip_last && i == 127)) s = s + mem[b*32 + i/4][8*(i%4) +: 8];
        end
        return s;
    endfunction

    // RAM secondary-port responder
    initial begin
        ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (ram_rvalid) outst = 1'b0;
            ram_gnt = 1'b0; ram_rvalid = 1'b0;
            if (rst) begin
                rv_cnt = 0; wait_cnt = 0; held = 1'b0; outst = 1'b0;
            end else begin
                if (rv_cnt > 0) begin
                    rv_cnt--;
                    if (rv_cnt == 0) begin ram_rvalid = 1'b1; ram_rdata = rd_hold; end
                end
                if (held) begin
                    check("req_stable", {ram_req, ram_we, ram_addr, ram_wdata, ram_wmask}, held_sig);
                    held = 1'b0;
                end
                if (ram_req) begin
                    if (wait_cnt < gnt_delay) begin
                        wait_cnt++;
                        held = 1'b1;
                        held_sig = {1'b1, ram_we, ram_addr, ram_wdata, ram_wmask};
                    end else begin
                        wait_cnt = 0;
                        ram_gnt = 1'b1;
                        if (ram_we) begin
                            check("wr_word", ram_addr[4:0], 5'd31);
                            n_wr++;
                            last_wmask = ram_wmask;
                            for (int k = 0; k < 4; k++)
                                if (ram_wmask[k]) mem[ram_addr][8*k +: 8] = ram_wdata[8*k +: 8];
                        end else begin
                            check("one_outstanding", outst, 1'b0);
                            check("rd_addr", ram_addr, n_rd[5:0]);
                            n_rd++;
                            outst = 1'b1;
                            rd_hold = mem[ram_addr];
                            rv_cnt = rv_lat;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (hpd === 1'b0) low_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    // One full update sequence checked against the reference model
    task automatic do_update(input string nm, input int i2c_hold, input bit commit_in_drain,
                             input bit req_in_sum);
        logic [7:0]  exp_byte [NB];
        logic [31:0] pre31 [NB];
        bit          exp_ok;
        int          exp_wr;
        int          cyc;
        bit          injected;
        exp_ok = 1'b1;
        for (int b = 0; b < NB; b++) begin
            pre31[b] = mem[b*32 + 31];
            exp_byte[b] = 8'h00 - blk_sum(b, 1'b1);
`ifndef EDID_CKSUM_FIX_EN
            if (blk_sum(b, 1'b0) != 8'h00) exp_ok = 1'b0;
`endif
        end
`ifdef EDID_CKSUM_FIX_EN
        exp_wr = NB;
`else
        exp_wr = 0;
`endif
        n_rd = 0; n_wr = 0; low_cnt = 0; done_cnt = 0; injected = 1'b0;
        i2c_active = (i2c_hold > 0);
        update_req = 1'b1;
        tick();
        update_req = 1'b0;
        check({nm, "_hpd_fall"}, hpd, 1'b0);
        check({nm, "_busy"}, busy, 1'b1);
        for (int i = 0; i < i2c_hold; i++) begin
            if (commit_in_drain && i == 1) commit = 1'b1;
            tick();
            commit = 1'b0;
            check({nm, "_drain_lock"}, lock, 1'b0);
            check({nm, "_drain_wr"}, host_wr_en, 1'b0);
        end
        i2c_active = 1'b0;
        tick();
        check({nm, "_lock"}, lock, 1'b1);
        check({nm, "_wr_en"}, host_wr_en, 1'b1);
        repeat ($urandom_range(0, 3)) tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check({nm, "_wr_closed"}, host_wr_en, 1'b0);
        cyc = 0;
        while (hpd !== 1'b1 && cyc < 3000) begin
            if (req_in_sum && !injected && n_rd == 5) begin
                update_req = 1'b1; injected = 1'b1;
            end
            tick();
            update_req = 1'b0;
            cyc++;
        end
        check({nm, "_hpd_rise"}, hpd, 1'b1);
        tick();
        check({nm, "_done_pulse"}, done, 1'b0);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_idle"}, {busy, lock, hpd}, 3'b001);
        check({nm, "_cksum_ok"}, cksum_ok, exp_ok);
        check({nm, "_reads"}, n_rd, 64);
        check({nm, "_writes"}, n_wr, exp_wr);
        check({nm, "_hpd_low"}, (low_cnt >= HPD_LOW), 1'b1);
`ifdef EDID_CKSUM_FIX_EN
        check({nm, "_wmask"}, last_wmask, 4'b1000);
        for (int b = 0; b < NB; b++)
            check({nm, "_patched"}, mem[b*32 + 31], {exp_byte[b], pre31[b][23:0]});
`else
        for (int b = 0; b < NB; b++)
            check({nm, "_untouched"}, mem[b*32 + 31], pre31[b]);
`endif
    endtask

    initial begin
        rst = 1'b1; update_req = 1'b0; commit = 1'b0; i2c_active = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outs", {hpd, busy, ram_req, lock, done, cksum_ok, host_wr_en}, 7'b0);
        rst = 1'b0;
        tick();

        // All bytes 8'h01: checksum byte must become 0x81
        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101;
        gnt_delay = 0; rv_lat = 1;
        do_update("ones", 0, 1'b0, 1'b0);
`ifdef EDID_CKSUM_FIX_EN
        check("ones_w31", mem[31], 32'h8101_0101);
        check("ones_w63", mem[63], 32'h8101_0101);
`else
        check("ones_bad_sum", cksum_ok, 1'b0);
`endif

        // DDC transaction in flight when the request arrives
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        gnt_delay = $urandom_range(0, 2); rv_lat = $urandom_range(1, 2);
        do_update("i2c", 5, 1'b0, 1'b0);

        // Slow RAM, valid checksums in place
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        for (int b = 0; b < NB; b++) mem[b*32 + 31][31:24] = 8'h00 - blk_sum(b, 1'b1);
        gnt_delay = 5; rv_lat = 3;
        do_update("slow", 0, 1'b0, 1'b0);

        // Stray commit in DRAIN and stray update request in SUM
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        gnt_delay = $urandom_range(0, 3); rv_lat = $urandom_range(1, 3);
        do_update("ignore", 4, 1'b1, 1'b1);

        // Reset in the middle of the checksum walk
        gnt_delay = 1; rv_lat = 2;
        update_req = 1'b1; tick(); update_req = 1'b0;
        tick(); tick();
        commit = 1'b1; tick(); commit = 1'b0;
        for (int i = 0; i < 400 && n_rd < 10; i++) tick();
        #2 rst = 1'b1;
        #1 check("rst_async", {hpd, lock, busy, ram_req, host_wr_en, done}, 6'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_req", ram_req, 1'b0);
        end
        rst = 1'b0;
        tick();
        check("rst_released", {hpd, busy, ram_req}, 3'b0);
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        do_update("after_rst", 0, 1'b0, 1'b0);

        // Block 0 sums to 8'h00, block 1 sums to 8'h05
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[31][31:24] = 8'h00 - blk_sum(0, 1'b1);
        mem[63][31:24] = 8'h05 - blk_sum(1, 1'b1);
        gnt_delay = 1; rv_lat = 2;
        do_update("bad_blk1", 0, 1'b0, 1'b0);
`ifndef EDID_CKSUM_FIX_EN
        check("bad_blk1_ok", cksum_ok, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
